fc_score_streamer: RTL and testbench

Accumulates final fully-connected-layer partial sums into one signed score per class, then streams the finished scores in class order (0 to NUM_CLASS-1), one per handshake, into the downstream `softmax` argmax stage. It is the producer end of the softmax score stream and sits between the FC PSUM output path and the softmax block in the handwritten-digit FPGA datapath.

---
 rtl/score_stream_pkg.sv | 18 +
 rtl/fc_score_streamer_if.sv | 42 ++++
 rtl/score_acc_sat.sv | 39 +++
 rtl/fc_score_streamer.sv | 122 ++++++++++++
 tb/tb_fc_score_streamer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/score_stream_pkg.sv
// Shared types and defaults for the FC score streamer.
// Holds the state enum, default sizes and the saturation limits at the default width.
package score_stream_pkg;

    localparam int unsigned NUM_CLASS_DEF = 10;
    localparam int unsigned DATA_W_DEF    = 21;
    localparam int unsigned IDX_W_DEF     = 4;

    // Saturation limits at the default score width.
    localparam logic signed [DATA_W_DEF-1:0] SAT_MAX_DEF = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic signed [DATA_W_DEF-1:0] SAT_MIN_DEF = {1'b1, {(DATA_W_DEF-1){1'b0}}};

    typedef enum logic [0:0] {
        StAccum,
        StDrain
    } state_e;

endpackage

// File: rtl/fc_score_streamer_if.sv
// Partial-sum input and score output handshake bundle.
// The master side is the producer of psums and the consumer of scores.
// The slave side is the streamer itself.
interface fc_score_streamer_if
    import score_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF
);

    logic signed [DATA_W-1:0] psum_in;
    logic        [IDX_W-1:0]  psum_idx;
    logic                     psum_valid;
    logic                     psum_last;
    logic                     psum_ready;
    logic                     out_en;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;

    modport master (
        output psum_in,
        output psum_idx,
        output psum_valid,
        output psum_last,
        output out_en,
        input  psum_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  psum_in,
        input  psum_idx,
        input  psum_valid,
        input  psum_last,
        input  out_en,
        output psum_ready,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/score_acc_sat.sv
// Combinational score accumulator: DATA_W + DATA_W -> DATA_W.
// SCORE_SAT_EN defined: the result clamps to the signed range on overflow.
// SCORE_SAT_EN undefined: the result wraps (two's complement).
module score_acc_sat
    import score_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_sum
);

    logic signed [DATA_W-1:0] w_raw;

    assign w_raw = i_a + i_b;

`ifdef SCORE_SAT_EN
    logic w_ovf_pos;
    logic w_ovf_neg;

    // Overflow only when both operands share a sign and the result sign differs.
    assign w_ovf_pos = ~i_a[DATA_W-1] & ~i_b[DATA_W-1] &  w_raw[DATA_W-1];
    assign w_ovf_neg =  i_a[DATA_W-1] &  i_b[DATA_W-1] & ~w_raw[DATA_W-1];

    // Clamp to the most positive or most negative representable score.
    always_comb begin
        o_sum = w_raw;
        if (w_ovf_pos) begin
            o_sum = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_ovf_neg) begin
            o_sum = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end
`else
    assign o_sum = w_raw;
`endif

endmodule

// File: rtl/fc_score_streamer.sv
// FC score streamer: accumulates final-layer partial sums per class, then streams
// NUM_CLASS scores in class order to the softmax stage.
// Optional feature: SCORE_SAT_EN selects saturating accumulation (see score_acc_sat).
module fc_score_streamer
    import score_stream_pkg::*;
#(
    parameter int unsigned NUM_CLASS = NUM_CLASS_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned IDX_W     = IDX_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fc_score_streamer_if.slave   bus,
    output logic                 o_frame_done,
    output logic                 o_idx_err
);

    state_e                   r_state;
    state_e                   w_state_next;
    logic signed [DATA_W-1:0] r_score [NUM_CLASS];
    logic        [IDX_W-1:0]  r_drain_idx;
    logic                     r_frame_done;
    logic                     r_idx_err;

    logic                     w_accept;
    logic                     w_drain_step;
    logic                     w_drain_end;
    logic                     w_drain_at_last;
    logic                     w_idx_ok;
    logic        [31:0]       w_idx_ext;
    logic        [IDX_W-1:0]  w_sel;
    logic signed [DATA_W-1:0] w_sum;

    // Zero-extend before comparing so NUM_CLASS = 2^IDX_W does not truncate.
    assign w_idx_ext       = {{(32-IDX_W){1'b0}}, bus.psum_idx};
    assign w_idx_ok        = (w_idx_ext < NUM_CLASS);
    assign w_sel           = w_idx_ok ? bus.psum_idx : '0;
    assign w_drain_at_last = (r_drain_idx == IDX_W'(NUM_CLASS - 1));

    score_acc_sat #(
        .DATA_W (DATA_W)
    ) u_acc (
        .i_a   (r_score[w_sel]),
        .i_b   (bus.psum_in),
        .o_sum (w_sum)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StAccum;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_drain_step = 1'b0;
        w_drain_end  = 1'b0;
        unique case (r_state)
            StAccum: begin
                w_accept = bus.psum_valid;
                // An out-of-range last beat still closes the frame.
                if (bus.psum_valid && bus.psum_last) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                w_drain_step = bus.out_en;
                if (bus.out_en && w_drain_at_last) begin
                    w_drain_end  = 1'b1;
                    w_state_next = StAccum;
                end
            end
            default: w_state_next = StAccum;
        endcase
    end

    // Score register file: accumulate in ACCUM, clear when the last score is consumed.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || w_drain_end) begin
            for (int k = 0; k < int'(NUM_CLASS); k++) begin
                r_score[k] <= '0;
            end
        end else if (w_accept && w_idx_ok) begin
            r_score[w_sel] <= w_sum;
        end
    end

    // Drain counter: advances on each consumed score, wraps to 0 at frame end.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || w_drain_end) begin
            r_drain_idx <= '0;
        end else if (w_drain_step) begin
            r_drain_idx <= r_drain_idx + IDX_W'(1);
        end
    end

    // Frame-done pulse and sticky index error.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_frame_done <= 1'b0;
            r_idx_err    <= 1'b0;
        end else begin
            r_frame_done <= w_drain_end;
            if (w_accept && !w_idx_ok) begin
                r_idx_err <= 1'b1;
            end
        end
    end

    assign bus.psum_ready = (r_state == StAccum);
    assign bus.out_valid  = (r_state == StDrain);
    // Registered-index mux; forced to 0 outside DRAIN so idle output stays clean.
    assign bus.out_data   = (r_state == StDrain) ? r_score[r_drain_idx] : '0;
    assign o_frame_done   = r_frame_done;
    assign o_idx_err      = r_idx_err;

endmodule

// File: tb/tb_fc_score_streamer.sv
// Self-checking bench for fc_score_streamer: directed frames, a saturation/wrap
// vector table, and randomized frames scored against a per-class arithmetic model.
module tb_fc_score_streamer;

    localparam int unsigned NUM_CLASS = 10;
    localparam int unsigned DATA_W    = 21;
    localparam int unsigned IDX_W     = 4;
    localparam longint      LIM       = longint'(1) << (DATA_W - 1);

    logic clk;
    logic rst_n;
    logic frame_done;
    logic idx_err;

    int n_checks;
    int n_err;

    longint model_score [NUM_CLASS];
    bit     model_err;

    fc_score_streamer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    fc_score_streamer #(
        .NUM_CLASS (NUM_CLASS),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bus),
        .o_frame_done (frame_done),
        .o_idx_err    (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (actual=running, required=finished)");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Score arithmetic straight from the rules: exact sum, then clamp or wrap.
    function automatic longint model_acc(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef SCORE_SAT_EN
        if (s > LIM - 1) s = LIM - 1;
        if (s < -LIM)    s = -LIM;
`else
        while (s > LIM - 1) s -= 2 * LIM;
        while (s < -LIM)    s += 2 * LIM;
`endif
        return s;
    endfunction

    task automatic model_clear_scores();
        for (int k = 0; k < int'(NUM_CLASS); k++) model_score[k] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.psum_valid = 1'b0;
        bus.psum_last  = 1'b0;
        bus.psum_idx   = '0;
        bus.psum_in    = '0;
        bus.out_en     = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        check("rst_psum_ready", longint'(bus.psum_ready), 1);
        check("rst_out_valid",  longint'(bus.out_valid), 0);
        check("rst_out_data",   longint'(bus.out_data), 0);
        check("rst_frame_done", longint'(frame_done), 0);
        check("rst_idx_err",    longint'(idx_err), 0);
        rst_n = 1'b1;
        model_clear_scores();
        model_err = 1'b0;
    endtask

    task automatic send(input int idx, input longint val, input bit last);
        check("psum_ready_accum", longint'(bus.psum_ready), 1);
        bus.psum_valid = 1'b1;
        bus.psum_idx   = IDX_W'(idx);
        bus.psum_in    = DATA_W'(val);
        bus.psum_last  = last;
        tick();
        bus.psum_valid = 1'b0;
        bus.psum_last  = 1'b0;
        if (idx < int'(NUM_CLASS)) model_score[idx] = model_acc(model_score[idx], val);
        else model_err = 1'b1;
    endtask

    // mode 0: out_en always 1; mode 1: pattern 1,0,0,1; mode 2: random out_en.
    task automatic drain(input int mode, input bit hold_valid);
        int beat;
        int cyc;
        bit en;
        beat = 0;
        cyc  = 0;
        bus.psum_valid = hold_valid;
        bus.psum_idx   = IDX_W'(2);
        bus.psum_in    = DATA_W'(77);
        bus.psum_last  = 1'b1;
        while (beat < int'(NUM_CLASS) && cyc < 300) begin
            case (mode)
                0:       en = 1'b1;
                1:       en = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: en = ($urandom_range(0, 9) < 7);
            endcase
            bus.out_en = en;
            check("drain_out_valid",  longint'(bus.out_valid), 1);
            check("drain_psum_ready", longint'(bus.psum_ready), 0);
            check("drain_out_data",   longint'(bus.out_data), model_score[beat]);
            check("drain_frame_done", longint'(frame_done), 0);
            tick();
            if (en) beat++;
            cyc++;
        end
        bus.out_en     = 1'b0;
        bus.psum_valid = 1'b0;
        bus.psum_last  = 1'b0;
        check("drain_beats", beat, NUM_CLASS);
        if (mode == 0) check("drain_cycles", cyc, NUM_CLASS);
        check("frame_done_pulse", longint'(frame_done), 1);
        check("ready_after_drain", longint'(bus.psum_ready), 1);
        check("valid_after_drain", longint'(bus.out_valid), 0);
        check("idx_err_level", longint'(idx_err), longint'(model_err));
        model_clear_scores();
        tick();
        check("frame_done_single", longint'(frame_done), 0);
    endtask

    typedef struct {
        longint a;
        longint b;
        longint exp_wrap;
        longint exp_sat;
    } sat_vec_t;

    sat_vec_t vecs [6];

    initial begin
        longint exp;
        n_checks  = 0;
        n_err     = 0;
        model_err = 1'b0;
        model_clear_scores();
        idle_inputs();
        rst_n = 1'b0;

        vecs[0] = '{a: 1048575,  b: 1,        exp_wrap: -1048576, exp_sat: 1048575};
        vecs[1] = '{a: -1048576, b: -1,       exp_wrap: 1048575,  exp_sat: -1048576};
        vecs[2] = '{a: -1048576, b: -1048576, exp_wrap: 0,        exp_sat: -1048576};
        vecs[3] = '{a: 1048575,  b: 1048575,  exp_wrap: -2,       exp_sat: 1048575};
        vecs[4] = '{a: 500,      b: -700,     exp_wrap: -200,     exp_sat: -200};
        vecs[5] = '{a: -1,       b: 1,        exp_wrap: 0,        exp_sat: 0};

        tick();
        apply_reset();

        // Basic frame: class k gets 100*k.
        for (int k = 0; k < int'(NUM_CLASS); k++) send(k, 100 * k, k == int'(NUM_CLASS) - 1);
        check("basic_first_beat", longint'(bus.out_data), 0);
        drain(0, 1'b0);

        // Multi-accumulate on class 3 with a stalling consumer.
        send(3, 5, 1'b0);
        send(3, 7, 1'b0);
        send(3, -2, 1'b1);
        check("multi_model_class3", model_score[3], 10);
        drain(1, 1'b0);

        // Saturation / wrap vectors on class 0.
        for (int i = 0; i < 6; i++) begin
            send(0, vecs[i].a, 1'b0);
            send(0, vecs[i].b, 1'b1);
`ifdef SCORE_SAT_EN
            exp = vecs[i].exp_sat;
`else
            exp = vecs[i].exp_wrap;
`endif
            check("sat_table_beat0", longint'(bus.out_data), exp);
            drain(0, 1'b0);
        end

        // Out-of-range index: flag goes sticky, scores untouched.
        send(12, 50, 1'b0);
        check("idx_err_set", longint'(idx_err), 1);
        for (int k = 0; k < int'(NUM_CLASS); k++) send(k, 3 * k + 1, k == int'(NUM_CLASS) - 1);
        drain(0, 1'b0);
        check("idx_err_sticky", longint'(idx_err), 1);

        // Input held valid during drain must be ignored.
        send(5, 123, 1'b0);
        send(1, -9, 1'b1);
        drain(0, 1'b1);
        send(2, 4, 1'b1);
        drain(0, 1'b0);

        // Reset after 4 consumed beats discards the frame.
        for (int k = 0; k < int'(NUM_CLASS); k++) send(k, 11 * k + 2, k == int'(NUM_CLASS) - 1);
        for (int b = 0; b < 4; b++) begin
            bus.out_en = 1'b1;
            check("pre_reset_data", longint'(bus.out_data), model_score[b]);
            tick();
        end
        bus.out_en = 1'b0;
        apply_reset();
        for (int k = 0; k < int'(NUM_CLASS); k++) send(k, -37 * k - 1, k == int'(NUM_CLASS) - 1);
        check("post_reset_beat0", longint'(bus.out_data), -1);
        drain(0, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            int nb;
            nb = int'($urandom_range(1, 14));
            for (int j = 0; j < nb; j++) begin
                int     idx;
                longint val;
                if ($urandom_range(0, 15) < 14) idx = int'($urandom_range(0, NUM_CLASS - 1));
                else idx = int'($urandom_range(NUM_CLASS, 15));
                case ($urandom_range(0, 5))
                    0:       val = LIM - 1;
                    1:       val = -LIM;
                    default: val = longint'($urandom_range(0, 2097151)) - LIM;
                endcase
                if ($urandom_range(0, 3) == 0) tick();
                send(idx, val, j == nb - 1);
            end
            drain(2, bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
